lane_serializer: RTL and testbench
==================================

# lane_serializer

Converts one 8-lane byte word (eight parallel 8-bit lanes, as carried between pipeline stages) into a stream of single bytes, one lane per accepted beat, with valid/ready flow control on both sides. Sits at the consuming end of a lane-parallel pipeline stage and feeds byte-wide sinks (output buffers, UART/host links). Sustains one byte per cycle with back-to-back words: the next word is accepted in the same cycle the last lane of the current word is accepted.

## Interface
- LANE_W, 8, width of each lane and of OutData; lane count fixed at 8.
- Clk  input  1  clock; all state updates on posedge Clk.
- Rst  input  1  synchronous, active-high reset.
- InValid  input  1  word on In1..In8 is valid.
- InReady  output  1  block accepts a word this cycle; transfer when InValid && InReady at a posedge.
- In1..In8  input  LANE_W each  lanes 1..8 of the input word.
- OutValid  output  1  OutData holds a valid byte.
- OutReady  input  1  sink accepts the byte; transfer when OutValid && OutReady at a posedge.
- OutData  output  LANE_W  current lane byte.
- OutIndex  output  3  lane number of OutData minus 1 (0 = lane 1).
- OutLast  output  1  high with the final lane of a word.

## Operation
- States: IDLE (no word held), SEND (word held, emitting lanes).
- Accepted word is captured whole into a 64-bit holding register; lane counter Idx (3 bits) selects OutData.
- IDLE: InReady=1, OutValid=0. On InValid: capture word, Idx=0, go SEND.
- SEND: OutValid=1; OutData=lane(Idx+1), OutIndex=Idx, OutLast=(Idx==7).
- Beat accepted with Idx<7: Idx+1, stay SEND.
- Beat accepted with Idx==7: if InValid, capture new word, Idx=0, stay SEND; else go IDLE.
- InReady = (state==IDLE) || (OutValid && OutReady && Idx==7); it is the only combinational path from OutReady and never depends on InValid.
- OutReady low: OutData/OutIndex/OutLast held stable, Idx frozen; no byte lost or repeated.
- Input lanes are sampled only on an input transfer; In1..In8 changing at other times has no effect.
- Reset values: state IDLE, Idx 0, holding register 0, OutValid 0, OutData 0, OutIndex 0, OutLast 0, InReady 0 while Rst high.
- Rst mid-word: held word discarded, no further beats emitted; InReady=1 on the first cycle after Rst falls.

## Timing
- Word accepted at edge N: lane 1 on OutValid in cycle N+1 (latency 1).
- With OutReady held high: lanes 1..8 on cycles N+1..N+8; next word (if presented) accepted at edge N+8, its lane 1 in cycle N+9 — no bubble.
- Throughput: 1 byte/cycle, 1 word per 8 cycles maximum.
- OutValid, once high, stays high until its beat transfers or Rst.
- Simultaneous last-lane transfer and InValid: both transfer at the same edge; OutLast drops with new lane 1.

## Configuration
- LANE_SER_MSB_FIRST_EN defined: lanes emitted 8 down to 1; OutIndex counts 7 down to 0; OutLast with lane 1 (OutIndex 0).
- Not defined: lanes emitted 1 to 8, OutIndex 0 to 7, OutLast with lane 8.
- Handshake, latency and reset behaviour identical in both builds.

## Structure
- Shared package lane_ser_pkg: LANES=8, LANE_W default, IDX_W=3, state enum {IDLE, SEND}.
- One sub-module: lane_ser_mux, combinational 8:1 LANE_W mux from holding register and Idx to OutData.
- FSM, counter, holding register and handshake logic in lane_serializer.

## Test plan
- Single word In1..In8=0x11..0x88, OutReady=1 -> OutData 0x11..0x88 on 8 consecutive cycles, OutIndex 0..7, OutLast only with 0x88, then OutValid=0.
- Two back-to-back words (0x01..0x08 then 0xA1..0xA8), InValid held high, OutReady=1 -> 16 contiguous beats, second word accepted same edge as 0x08, no gap.
- OutReady low for 3 cycles on lane 4 (word 0x10..0x80) -> OutData 0x40, OutIndex 3 held stable; sequence resumes 0x40,0x50..0x80 with no duplicate or drop.
- Rst asserted after lane 3 accepted -> next cycle OutValid=0, OutData=0, OutIndex=0; after release InReady=1, new word 0xF1..0xF8 emitted from lane 1.
- In1..In8 toggled while in SEND with InValid=0 -> emitted bytes equal the captured word only.
- LANE_SER_MSB_FIRST_EN build, word 0x11..0x88 -> OutData 0x88..0x11, OutIndex 7..0, OutLast with 0x11.

Source files
------------

// File: rtl/lane_ser_pkg.sv
// lane_ser_pkg
// Shared constants and types for the lane serializer slice.
//   LANES          : number of lanes per input word (fixed at 8)
//   LANE_W_DEFAULT : default lane / output byte width
//   IDX_W          : width of the lane counter and OutIndex
//   state_t        : serializer FSM states
package lane_ser_pkg;

  localparam int LANES          = 8;
  localparam int LANE_W_DEFAULT = 8;
  localparam int IDX_W          = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_ser_mux.sv
// lane_ser_mux
// Combinational 8:1 lane selector from the holding register.
// Ports:
//   word : packed word, lane 1 in the least significant LANE_W bits
//   sel  : zero-based lane number to select
//   data : selected lane
module lane_ser_mux
  import lane_ser_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEFAULT
) (
  input  logic [LANES*LANE_W-1:0] word,
  input  logic [IDX_W-1:0]        sel,
  output logic [LANE_W-1:0]       data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sel == IDX_W'(i)) data = word[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// lane_serializer
// Turns one 8-lane word into eight single-lane beats with valid/ready
// flow control on both sides. The next word is accepted on the same edge
// as the last lane of the current word, so back-to-back words stream at
// one lane per cycle with no bubble.
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   InValid, InReady  : input word handshake
//   In1..In8          : input lanes 1..8
//   OutValid, OutReady: output beat handshake
//   OutData           : current lane
//   OutIndex          : zero-based lane number of OutData
//   OutLast           : final lane of the word
// Build option: define LANE_SER_MSB_FIRST_EN to emit lanes 8 down to 1.
module lane_serializer
  import lane_ser_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [LANE_W-1:0] In1,
  input  logic [LANE_W-1:0] In2,
  input  logic [LANE_W-1:0] In3,
  input  logic [LANE_W-1:0] In4,
  input  logic [LANE_W-1:0] In5,
  input  logic [LANE_W-1:0] In6,
  input  logic [LANE_W-1:0] In7,
  input  logic [LANE_W-1:0] In8,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [LANE_W-1:0] OutData,
  output logic [IDX_W-1:0]  OutIndex,
  output logic              OutLast
);

`ifdef LANE_SER_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(LANES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);
`endif

  state_t                  state_p1;
  logic [IDX_W-1:0]        idx_p1;
  logic [LANES*LANE_W-1:0] word_p1;

  logic out_xfer;
  logic last_xfer;
  logic in_xfer;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
`ifdef LANE_SER_MSB_FIRST_EN
    return idx - IDX_W'(1);
`else
    return idx + IDX_W'(1);
`endif
  endfunction

  assign OutValid  = (state_p1 == SEND);
  assign out_xfer  = OutValid && OutReady;
  assign last_xfer = out_xfer && (idx_p1 == LAST_IDX);
  // InReady looks only at state, OutReady and the counter, never InValid.
  assign InReady   = !Rst && ((state_p1 == IDLE) || last_xfer);
  assign in_xfer   = InValid && InReady;

  // Stage p0 -> p1: capture word, advance lane counter and FSM
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_p1 <= IDLE;
      idx_p1   <= '0;
      word_p1  <= '0;
    end else begin
      if (in_xfer) begin
        word_p1  <= {In8, In7, In6, In5, In4, In3, In2, In1};
        idx_p1   <= FIRST_IDX;
        state_p1 <= SEND;
      end else if (last_xfer) begin
        state_p1 <= IDLE;
      end else if (out_xfer) begin
        idx_p1   <= next_idx(idx_p1);
      end
    end
  end

  // Stage p1 -> output: lane select from held word
  lane_ser_mux #(
    .LANE_W (LANE_W)
  ) u_mux (
    .word (word_p1),
    .sel  (idx_p1),
    .data (OutData)
  );

  assign OutIndex = idx_p1;
  assign OutLast  = OutValid && (idx_p1 == LAST_IDX);

endmodule

// File: tb/tb_lane_serializer.sv
module tb_lane_serializer;
  import lane_ser_pkg::*;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       InValid;
  logic       InReady;
  logic [7:0] In1, In2, In3, In4, In5, In6, In7, In8;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] OutData;
  logic [2:0] OutIndex;
  logic       OutLast;

  int n_chk  = 0;
  int n_fail = 0;

  lane_serializer #(.LANE_W(8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .In1      (In1),
    .In2      (In2),
    .In3      (In3),
    .In4      (In4),
    .In5      (In5),
    .In6      (In6),
    .In7      (In7),
    .In8      (In8),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .OutIndex (OutIndex),
    .OutLast  (OutLast)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_word(input logic [63:0] v);
    {In8, In7, In6, In5, In4, In3, In2, In1} = v;
  endtask

  // Zero-based lane emitted on beat b of a word.
  function automatic int lane_of(input int b);
`ifdef LANE_SER_MSB_FIRST_EN
    return 7 - b;
`else
    return b;
`endif
  endfunction

  function automatic logic [7:0] lane_val(input logic [63:0] v, input int l);
    return v[l*8 +: 8];
  endfunction

  task automatic chk_beat(input string tag, input logic [63:0] v, input int b);
    chk({tag, "_vld"}, 64'(OutValid), 64'd1);
    chk({tag, "_data"}, 64'(OutData), 64'(lane_val(v, lane_of(b))));
    chk({tag, "_idx"}, 64'(OutIndex), 64'(lane_of(b)));
    chk({tag, "_last"}, 64'(OutLast), 64'(b == 7));
  endtask

  // Word already accepted; stream all 8 beats with OutReady high.
  task automatic drain_word(input string tag, input logic [63:0] v);
    for (int b = 0; b < 8; b++) begin
      chk_beat(tag, v, b);
      tick();
    end
    chk({tag, "_done_vld"}, 64'(OutValid), 64'd0);
  endtask

  task automatic accept_word(input logic [63:0] v);
    set_word(v);
    InValid = 1'b1;
    chk("accept_rdy", 64'(InReady), 64'd1);
    tick();
    InValid = 1'b0;
  endtask

  localparam logic [63:0] W_A  = 64'h8877665544332211;
  localparam logic [63:0] W_B0 = 64'h0807060504030201;
  localparam logic [63:0] W_B1 = 64'hA8A7A6A5A4A3A2A1;
  localparam logic [63:0] W_C  = 64'h8070605040302010;
  localparam logic [63:0] W_D  = 64'hF8F7F6F5F4F3F2F1;
  localparam logic [63:0] W_E  = 64'h5A4B3C2D1E0F6978;

  initial begin
    Rst = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    set_word(64'd0);
    tick();
    tick();

    // Reset state
    chk("rst_vld", 64'(OutValid), 64'd0);
    chk("rst_data", 64'(OutData), 64'd0);
    chk("rst_idx", 64'(OutIndex), 64'd0);
    chk("rst_last", 64'(OutLast), 64'd0);
    chk("rst_rdy", 64'(InReady), 64'd0);
    Rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(InReady), 64'd1);
    chk("idle_vld", 64'(OutValid), 64'd0);

    // Single word
    accept_word(W_A);
    drain_word("single", W_A);

    // Back-to-back words, InValid held high
    set_word(W_B0);
    InValid = 1'b1;
    tick();
    set_word(W_B1);
    for (int b = 0; b < 8; b++) begin
      chk_beat("b2b0", W_B0, b);
      chk("b2b0_rdy", 64'(InReady), 64'(b == 7));
      tick();
    end
    InValid = 1'b0;
    set_word(64'd0);
    drain_word("b2b1", W_B1);

    // Stall on the fourth beat
    accept_word(W_C);
    for (int b = 0; b < 3; b++) begin
      chk_beat("stall_pre", W_C, b);
      tick();
    end
    OutReady = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk_beat("stall_hold", W_C, 3);
      chk("stall_rdy", 64'(InReady), 64'd0);
      tick();
    end
    OutReady = 1'b1;
    for (int b = 3; b < 8; b++) begin
      chk_beat("stall_post", W_C, b);
      tick();
    end
    chk("stall_done_vld", 64'(OutValid), 64'd0);

    // Reset after three beats
    accept_word(W_A);
    for (int b = 0; b < 3; b++) begin
      chk_beat("midrst_pre", W_A, b);
      tick();
    end
    Rst = 1'b1;
    tick();
    chk("midrst_vld", 64'(OutValid), 64'd0);
    chk("midrst_data", 64'(OutData), 64'd0);
    chk("midrst_idx", 64'(OutIndex), 64'd0);
    Rst = 1'b0;
    #1;
    chk("midrst_rdy", 64'(InReady), 64'd1);
    accept_word(W_D);
    drain_word("after_rst", W_D);

    // Input lanes toggled while sending
    accept_word(W_E);
    for (int b = 0; b < 8; b++) begin
      set_word({$urandom, $urandom});
      chk_beat("toggle", W_E, b);
      tick();
    end
    chk("toggle_done_vld", 64'(OutValid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
